// File: rtl/muldiv_rv32m.sv
// muldiv_rv32m: iterative RV32M multiply/divide, one bit per cycle over 32 cycles.
// Divide-by-zero and signed overflow bypass the iteration and complete at the accept edge.
module muldiv_rv32m #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out,
    output logic            wb_rdwrite
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [4:0]          cnt;
    logic [2:0]          op;
    logic                neg_q;
    logic                neg_r;
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     rem;
    logic [2*XLEN-1:0]   prod;

    logic                a_sgn;
    logic                b_sgn;
    logic                neg_a;
    logic                neg_b;
    logic [XLEN-1:0]     a_abs;
    logic [XLEN-1:0]     b_abs;
    logic                div_zero;
    logic                ovf;
    logic [XLEN-1:0]     fast_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_nx;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN:0]       shifted;
    logic                fits;
    logic [XLEN-1:0]     rem_nx;
    logic [XLEN-1:0]     q_nx;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     remd;
    logic [XLEN-1:0]     calc_res;

    always_comb begin
        a_sgn    = funct3[2] ? !funct3[0] : !(funct3[1] & funct3[0]);
        b_sgn    = funct3[2] ? !funct3[0] : !funct3[1];
        neg_a    = a_sgn & rs1[XLEN-1];
        neg_b    = b_sgn & rs2[XLEN-1];
        a_abs    = neg_a ? -rs1 : rs1;
        b_abs    = neg_b ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        ovf      = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
        fast_res = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
        // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, prod[0] ? opnd : {XLEN{1'b0}}};
        prod_nx  = {mul_sum, prod[XLEN-1:1]};
        prod_s   = neg_q ? -prod_nx : prod_nx;
        // Divide: dividend sits in the low half and is replaced by quotient bits.
        shifted  = {rem, prod[XLEN-1]};
        fits     = shifted >= {1'b0, opnd};
        rem_nx   = fits ? shifted[XLEN-1:0] - opnd : shifted[XLEN-1:0];
        q_nx     = {prod[XLEN-2:0], fits};
        quo      = neg_q ? -q_nx : q_nx;
        remd     = neg_r ? -rem_nx : rem_nx;
        calc_res = op[2] ? (op[1] ? remd : quo) :
                   (op[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    end

    assign wb_rdwrite = done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            opnd        <= '0;
            rem         <= '0;
            prod        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            rd_addr_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op          <= funct3;
                        rd_addr_out <= rd_addr_in;
                        neg_q       <= neg_a ^ neg_b;
                        neg_r       <= neg_a;
                        cnt         <= '0;
                        rem         <= '0;
                        opnd        <= funct3[2] ? b_abs : a_abs;
                        prod        <= {{XLEN{1'b0}}, funct3[2] ? a_abs : b_abs};
                        busy        <= 1'b1;
                        if (div_zero || ovf) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod <= op[2] ? {prod[2*XLEN-1:XLEN], q_nx} : prod_nx;
                    rem  <= rem_nx;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= calc_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_rv32m.sv
// tb_muldiv_rv32m: scoreboard bench for muldiv_rv32m; expected {rd, result} pairs are queued at issue.
module tb_muldiv_rv32m;
    logic        clock = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] rs1 = 0;
    logic [31:0] rs2 = 0;
    logic [4:0]  rd_addr_in = 0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;
    logic        wb_rdwrite;

    int vectors = 0;
    int errors = 0;
    logic [36:0] sb[$];

    muldiv_rv32m #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd_addr_in(rd_addr_in), .busy(busy), .done(done),
        .result(result), .rd_addr_out(rd_addr_out), .wb_rdwrite(wb_rdwrite)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        if (f[2] && b == 0) return f[1] ? a : 32'hFFFFFFFF;
        if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
        case (f)
            3'd0: p = sa * sbv;
            3'd1: p = sa * sbv;
            3'd2: p = sa * ub;
            3'd3: p = {32'b0, a} * {32'b0, b};
            3'd4: p = sa / sbv;
            3'd5: p = ua / ub;
            3'd6: p = sa % sbv;
            default: p = ua % ub;
        endcase
        return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat, input string nm);
        logic [36:0] e;
        int n;
        sb.push_back({rd, exp});
        @(negedge clock);
        start = 1; funct3 = f; rs1 = a; rs2 = b; rd_addr_in = rd;
        @(negedge clock);
        start = 0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom); rd_addr_in = 5'($urandom);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
        end
        e = sb.pop_front();
        vectors++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", nm, n, lat);
        end
        if (done) begin
            vectors++;
            if ({rd_addr_out, result} !== e) begin
                errors++;
                $display("FAIL %s result: got rd=%0d res=%h, want rd=%0d res=%h", nm, rd_addr_out, result, e[36:32], e[31:0]);
            end
            vectors++;
            if (wb_rdwrite !== 1'b1) begin
                errors++;
                $display("FAIL %s wb_rdwrite: got %b, want 1", nm, wb_rdwrite);
            end
        end
        @(negedge clock);
        vectors++;
        if ({done, wb_rdwrite, busy} !== 3'b000) begin
            errors++;
            $display("FAIL %s after-done: got done/wb/busy=%b, want 000", nm, {done, wb_rdwrite, busy});
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({busy, done, wb_rdwrite, result, rd_addr_out} !== 40'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b wb=%b res=%h rd=%0d, want all 0", busy, done, wb_rdwrite, result, rd_addr_out);
        end
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'h0000002A, 32, "mul_7x6");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, 32, "mulh_m1");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 32, "mulhu_max");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 32, "mulhsu_m1");
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001, 32, "mul_m1");
    endtask

    task automatic test_div();
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 32, "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 32, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 5'd8, 32'd14, 32, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 32, "remu_100_7");
    endtask

    task automatic test_fast_path();
        run_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 0, "div_by_zero");
        run_op(3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 0, "remu_by_zero");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0, 0, "rem_ovf");
    endtask

    task automatic test_random();
        logic [2:0] f;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            f = 3'(i);
            a = $urandom;
            b = (i % 4 == 3) ? 32'($urandom_range(1, 50)) : $urandom;
            run_op(f, a, b, 5'(i + 14), model(f, a, b), 32, "random");
        end
    endtask

    task automatic test_start_ignored();
        logic [36:0] e;
        int n;
        sb.push_back({5'd7, 32'h00012340});
        @(negedge clock);
        start = 1; funct3 = 3'd0; rs1 = 32'h1234; rs2 = 32'h10; rd_addr_in = 5'd7;
        @(negedge clock);
        start = 0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
            if (n == 5) begin
                start = 1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0; rd_addr_in = 5'd30;
            end else begin
                start = 0;
            end
        end
        e = sb.pop_front();
        vectors++;
        if (n !== 32 || {rd_addr_out, result} !== e) begin
            errors++;
            $display("FAIL start_ignored: got lat=%0d rd=%0d res=%h, want lat=32 rd=%0d res=%h", n, rd_addr_out, result, e[36:32], e[31:0]);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        @(negedge clock);
        start = 1; funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13; rd_addr_in = 5'd21;
        @(negedge clock);
        start = 0;
        repeat (10) @(negedge clock);
        reset_n = 0;
        #1;
        vectors++;
        if ({busy, done, wb_rdwrite, result, rd_addr_out} !== 40'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b res=%h rd=%0d, want all 0", busy, done, result, rd_addr_out);
        end
        repeat (2) @(negedge clock);
        reset_n = 1;
        pulses = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", pulses);
        end
        run_op(3'd0, 32'd3, 32'd3, 5'd22, 32'd9, 32, "mul_3x3_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [36:0] e;
        int t1, t2, n;
        sb.push_back({5'd1, 32'd6});
        sb.push_back({5'd2, 32'd4});
        @(negedge clock);
        start = 1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd3; rd_addr_in = 5'd1;
        @(negedge clock);
        funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd2; rd_addr_in = 5'd2;
        t1 = -1; t2 = -1;
        for (n = 0; n < 80; n++) begin
            if (done) begin
                if (t1 < 0) t1 = n; else t2 = n;
                e = sb.pop_front();
                vectors++;
                if ({rd_addr_out, result} !== e) begin
                    errors++;
                    $display("FAIL b2b_result: got rd=%0d res=%h, want rd=%0d res=%h", rd_addr_out, result, e[36:32], e[31:0]);
                end
            end
            if (n == 34) start = 0;
            @(negedge clock);
        end
        vectors++;
        if (t1 !== 32 || t2 !== 66) begin
            errors++;
            $display("FAIL b2b_timing: got done at %0d and %0d, want 32 and 66", t1, t2);
        end
        vectors++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
